// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: two-requester round-robin front end for the command-driven RAM.
// Each granted word transaction becomes a two-command RAM sequence. A read
// result (or a read timeout) is returned as a one-cycle response pulse to the
// requester that owns the transaction.
module ram_cmd_arbiter #(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_we,
    input  logic [2*ADDR_SIZE-1:0] req_addr,
    input  logic [2*ADDR_SIZE-1:0] req_wdata,
    output logic [1:0]             req_ready,
    output logic [1:0]             rsp_valid,
    output logic [ADDR_SIZE-1:0]   rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [ADDR_SIZE+1:0]   ram_din,
    output logic                   ram_rx_valid,
    input  logic [ADDR_SIZE-1:0]   ram_dout,
    input  logic                   ram_tx_valid
);

    localparam int CW = $clog2(RD_TIMEOUT + 1);

    // RAM opcodes
    localparam logic [1:0] OP_WADDR = 2'b00;
    localparam logic [1:0] OP_WDATA = 2'b01;
    localparam logic [1:0] OP_RADDR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CMD1,
        CMD2,
        WAIT_RD,
        RESP
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   last_grant;
    logic                   grant;
    logic                   we;
    logic [ADDR_SIZE-1:0]   addr;
    logic [ADDR_SIZE-1:0]   wdata;
    logic [ADDR_SIZE-1:0]   data;
    logic                   err;
    logic [CW-1:0]          cnt;

    logic                   any_req;
    logic                   sel;
    logic                   sel_we;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [ADDR_SIZE-1:0]   sel_wdata;
    logic                   timeout;

    assign any_req = |req_valid;
    assign timeout = (cnt == CW'(RD_TIMEOUT));

    // Round-robin pick: on a tie the requester that did not win last goes;
    // a lone requester always wins.
    always_comb begin
        sel = req_valid[1];
        if (req_valid == 2'b11) sel = ~last_grant;
    end

    // Payload of the requester being picked this cycle
    always_comb begin
        sel_we    = sel ? req_we[1] : req_we[0];
        sel_addr  = sel ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE]  : req_addr[ADDR_SIZE-1:0];
        sel_wdata = sel ? req_wdata[2*ADDR_SIZE-1:ADDR_SIZE] : req_wdata[ADDR_SIZE-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and the combinational accept strobe
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        case (state)
            IDLE: begin
                if (any_req) begin
                    req_ready = sel ? 2'b10 : 2'b01;
                    state_nxt = CMD1;
                end
            end
            CMD1:    state_nxt = CMD2;
            CMD2:    state_nxt = we ? RESP : WAIT_RD;
            WAIT_RD: if (ram_tx_valid || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction latch, read capture and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            we         <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            data       <= '0;
            err        <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= sel;
                        last_grant <= sel;
                        we         <= sel_we;
                        addr       <= sel_addr;
                        wdata      <= sel_wdata;
                        data       <= '0;
                        err        <= 1'b0;
                    end
                end
                // WAIT_RD always starts with a fresh count
                CMD2: cnt <= '0;
                WAIT_RD: begin
                    if (ram_tx_valid) begin
                        data <= ram_dout;
                    end else if (timeout) begin
                        err  <= 1'b1;
                        data <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the registered state and transaction latch
    always_comb begin
        ram_din      = '0;
        ram_rx_valid = 1'b0;
        rsp_valid    = 2'b00;
        rsp_data     = '0;
        rsp_err      = 1'b0;
        case (state)
            CMD1: begin
                ram_rx_valid = 1'b1;
                ram_din      = {(we ? OP_WADDR : OP_RADDR), addr};
            end
            CMD2: begin
                ram_rx_valid = 1'b1;
                ram_din      = we ? {OP_WDATA, wdata} : {OP_READ, {ADDR_SIZE{1'b0}}};
            end
            RESP: begin
                rsp_valid = grant ? 2'b10 : 2'b01;
                rsp_data  = data;
                rsp_err   = err;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter with a small behavioural model of the
// command-driven RAM attached to its RAM side.
module tb_ram_cmd_arbiter;

    localparam int AS = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_we = '0;
    logic [2*AS-1:0] req_addr = '0;
    logic [2*AS-1:0] req_wdata = '0;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic [AS-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;
    logic [AS+1:0] ram_din;
    logic          ram_rx_valid;
    logic [AS-1:0] ram_dout;
    logic          ram_tx_valid;

    // RAM model state
    logic [AS-1:0] mem [256];
    logic [AS-1:0] wa = '0;
    logic [AS-1:0] ra = '0;
    logic [AS-1:0] ram_q = '0;
    logic          ram_txv = 1'b0;
    logic          mute = 1'b0;

    int errs = 0;
    int checks = 0;

    ram_cmd_arbiter #(.ADDR_SIZE(AS), .RD_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid)
    );

    always #5 clk = ~clk;

    assign ram_dout     = ram_q;
    assign ram_tx_valid = ram_txv & ~mute;

    // Command-driven RAM: tx_valid is a level held until the next read-address load
    always @(posedge clk) begin
        if (ram_rx_valid) begin
            case (ram_din[AS+1:AS])
                2'b00: wa <= ram_din[AS-1:0];
                2'b01: mem[wa] <= ram_din[AS-1:0];
                2'b10: begin ra <= ram_din[AS-1:0]; ram_txv <= 1'b0; end
                default: begin ram_q <= mem[ra]; ram_txv <= 1'b1; end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic w, input logic [7:0] a, input logic [7:0] d);
        req_valid[r]        = 1'b1;
        req_we[r]           = w;
        req_addr[r*AS +: AS]  = a;
        req_wdata[r*AS +: AS] = d;
    endtask

    // Lone write from requester r, starting from IDLE
    task automatic do_write(input int r, input logic [7:0] a, input logic [7:0] d, input string tag);
        @(negedge clk); set_req(r, 1'b1, a, d); #1;
        chk({tag, "_rdy"}, req_ready, 32'(2'b01 << r));
        @(negedge clk); req_valid[r] = 1'b0; #1;
        chk({tag, "_cmd1"}, ram_din, {22'd0, 2'b00, a});
        chk({tag, "_rx1"}, ram_rx_valid, 1);
        @(negedge clk); #1;
        chk({tag, "_cmd2"}, ram_din, {22'd0, 2'b01, d});
        @(negedge clk); #1;
        chk({tag, "_rsp"}, rsp_valid, 32'(2'b01 << r));
        chk({tag, "_rdat"}, rsp_data, 0);
        chk({tag, "_rerr"}, rsp_err, 0);
        @(negedge clk); #1;
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_rsp0"}, rsp_valid, 0);
    endtask

    // Lone read from requester r with the RAM answering one cycle after CMD2
    task automatic do_read(input int r, input logic [7:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk); set_req(r, 1'b0, a, 8'h00); #1;
        chk({tag, "_rdy"}, req_ready, 32'(2'b01 << r));
        @(negedge clk); req_valid[r] = 1'b0; #1;
        chk({tag, "_cmd1"}, ram_din, {22'd0, 2'b10, a});
        @(negedge clk); #1;
        chk({tag, "_cmd2"}, ram_din, 32'h300);
        @(negedge clk); #1;
        chk({tag, "_wrx"}, ram_rx_valid, 0);
        chk({tag, "_wrsp"}, rsp_valid, 0);
        @(negedge clk); #1;
        chk({tag, "_rsp"}, rsp_valid, 32'(2'b01 << r));
        chk({tag, "_rdat"}, rsp_data, 32'(exp));
        chk({tag, "_rerr"}, rsp_err, 0);
        @(negedge clk); #1;
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_rspd", rsp_data, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_rx", ram_rx_valid, 0);
        @(negedge clk); rst_n = 1'b1;

        // Basic write then read-back
        do_write(0, 8'h3C, 8'hA5, "w0");
        do_read(0, 8'h3C, 8'hA5, "r0");

        // Both requesters held from reset release: grants alternate 0,1,0,1
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 8'h10, 8'h11);
        set_req(1, 1'b1, 8'h20, 8'h22);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_rdy", req_ready, (k % 2 == 0) ? 1 : 2);
            @(negedge clk); #1;
            chk("rr_cmd1", ram_din, (k % 2 == 0) ? 32'h010 : 32'h020);
            chk("rr_busyrdy", req_ready, 0);
            @(negedge clk); #1;
            chk("rr_cmd2", ram_din, (k % 2 == 0) ? 32'h111 : 32'h122);
            @(negedge clk); #1;
            chk("rr_rsp", rsp_valid, (k % 2 == 0) ? 1 : 2);
            chk("rr_gap", ram_rx_valid, 0);
            @(negedge clk);
        end
        req_valid = 2'b00;

        // Read timeout with the RAM silent
        mute = 1'b1;
        @(negedge clk); set_req(0, 1'b0, 8'h3C, 8'h00); #1;
        chk("to_rdy", req_ready, 1);
        @(negedge clk); req_valid[0] = 1'b0;
        for (int k = 1; k < 8; k++) begin
            #1;
            chk("to_wait_rsp", rsp_valid, 0);
            chk("to_wait_busy", busy, 1);
            @(negedge clk);
        end
        #1;
        chk("to_rsp", rsp_valid, 1);
        chk("to_err", rsp_err, 1);
        chk("to_dat", rsp_data, 0);
        @(negedge clk); #1;
        chk("to_idle", busy, 0);
        mute = 1'b0;

        // Stale tx_valid high during a write: no extra response, reads still fresh
        do_write(1, 8'h3C, 8'h5A, "sw");
        @(negedge clk); #1;
        chk("sw_extra", rsp_valid, 0);
        do_read(1, 8'h20, 8'h22, "sr1");
        do_read(0, 8'h3C, 8'h5A, "sr0");

        // Reset during CMD2 of a read
        @(negedge clk); set_req(0, 1'b0, 8'h3C, 8'h00); #1;
        chk("mr_rdy", req_ready, 1);
        @(negedge clk); req_valid[0] = 1'b0;
        @(negedge clk); #1;
        chk("mr_cmd2", ram_din, 32'h300);
        rst_n = 1'b0; #1;
        chk("mr_din", ram_din, 0);
        chk("mr_rx", ram_rx_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_rspv", rsp_valid, 0);
        @(negedge clk); #1;
        chk("mr_rspv2", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 8'h40, 8'h44);
        set_req(1, 1'b1, 8'h50, 8'h55);
        #1;
        chk("mr_grant", req_ready, 1);
        @(negedge clk); req_valid = 2'b00; #1;
        chk("mr_cmd1", ram_din, 32'h040);
        @(negedge clk);
        @(negedge clk); #1;
        chk("mr_rsp", rsp_valid, 1);
        @(negedge clk);

        // Lone requester 1 wins whatever last_grant says
        do_write(1, 8'h60, 8'h66, "l1a");
        do_write(1, 8'h61, 8'h67, "l1b");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
